// File: rtl/noc_local_flit_buffer.sv
// Purpose: flit FIFO between a node sender and the router local input, with packet framing checks.
// Latency: 1 cycle from input write to out_valid (no bypass); outputs are driven from the FIFO head.
// Backpressure: in_ready = !full, registered from next-state occupancy; badly framed flits are still accepted.
// Optional: define NOC_LOCAL_BUF_STORE_FWD_EN for store-and-forward output gating (default: cut-through).
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_local_flit_buffer #(
  parameter int FLIT_WIDTH = `Noc_Data_Width,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_is_header,
  input  logic                  in_is_tail,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_is_header,
  output logic                  out_is_tail,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int EW = FLIT_WIDTH + 2;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  // Each entry holds {header, tail, payload}
  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [OW-1:0]  occ;
  logic [OW-1:0]  occ_nxt;
  logic           in_ready_q;
  logic           in_fire;
  logic           push;
  logic           pop;
  logic           empty;
  logic           full;
  logic           sf_deadlock;

  state_t         state;
  state_t         state_nxt;
  logic           wr_en;
  logic           pkt_inc;
  logic           frame_err;

  assign in_ready = in_ready_q;
  assign in_fire  = in_valid && in_ready_q;
  assign push     = in_fire && wr_en;
  assign pop      = out_valid && out_ready;
  assign empty    = (occ == '0);
  assign full     = (occ == FULL_OCC);

  assign head          = mem[rd_ptr];
  assign out_is_header = head[EW-1];
  assign out_is_tail   = head[EW-2];
  assign out_flit      = head[FLIT_WIDTH-1:0];

  // Next occupancy; push and pop together leave it unchanged
  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + OW'(1);
      2'b01:   occ_nxt = occ - OW'(1);
      default: occ_nxt = occ;
    endcase
  end

  // FIFO storage, pointers and registered in_ready; reset clears stored flits
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_is_header, in_is_tail, in_flit};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ        <= occ_nxt;
      in_ready_q <= (occ_nxt != FULL_OCC);
    end
  end

  // Framing state register
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Framing next state: a tail always closes the packet, a lone header opens one
  always_comb begin
    state_nxt = state;
    if (in_fire) begin
      case (state)
        ST_IDLE: state_nxt = (in_is_header && !in_is_tail) ? ST_BODY : ST_IDLE;
        ST_BODY: state_nxt = in_is_tail ? ST_IDLE : ST_BODY;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Framing outputs: orphans outside a packet are dropped, a header inside one is an error but kept
  always_comb begin
    wr_en     = 1'b0;
    pkt_inc   = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_IDLE: begin
        wr_en     = in_is_header;
        pkt_inc   = in_is_header && in_is_tail;
        frame_err = !in_is_header;
      end
      ST_BODY: begin
        wr_en     = 1'b1;
        pkt_inc   = in_is_tail;
        frame_err = in_is_header;
      end
      default: begin
        wr_en     = 1'b0;
        pkt_inc   = 1'b0;
        frame_err = 1'b0;
      end
    endcase
  end

`ifdef NOC_LOCAL_BUF_STORE_FWD_EN
  logic [OW-1:0] tails_stored;
  logic          fwd_active;
  logic          tail_push;
  logic          tail_pop;

  assign tail_push   = push && in_is_tail;
  assign tail_pop    = pop && out_is_tail;
  // A full FIFO with no complete packet can never drain by itself, so release it
  assign sf_deadlock = full && (tails_stored == '0);
  assign out_valid   = !empty && ((tails_stored != '0) || fwd_active || sf_deadlock);

  // Count complete packets held in the FIFO
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      tails_stored <= '0;
    end else begin
      case ({tail_push, tail_pop})
        2'b10:   tails_stored <= tails_stored + OW'(1);
        2'b01:   tails_stored <= tails_stored - OW'(1);
        default: tails_stored <= tails_stored;
      endcase
    end
  end

  // Once a packet has started leaving, keep it flowing until its tail is popped
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      fwd_active <= 1'b0;
    end else if (pop) begin
      fwd_active <= !out_is_tail;
    end
  end
`else
  assign sf_deadlock = 1'b0;
  assign out_valid   = !empty;
`endif

  // Packet and error statistics; error counter saturates, packet counter wraps
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      pkt_count <= '0;
      err_count <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (in_fire && pkt_inc) begin
        pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
      if (in_fire && frame_err) begin
        if (err_count != '1) begin
          err_count <= err_count + CNT_WIDTH'(1);
        end
        err_flag <= 1'b1;
      end
      if (sf_deadlock) begin
        err_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_local_flit_buffer.sv
// Purpose: self-checking bench for noc_local_flit_buffer (FLIT_WIDTH=8, DEPTH=4, CNT_WIDTH=4).
// Latency: checks 1-cycle write-to-out_valid and registered in_ready behaviour.
// Backpressure: drives out_ready low to fill the FIFO and confirms in_ready drops and nothing is lost.
module tb_noc_local_flit_buffer;

  localparam int FW = 8;
  localparam int CW = 4;

  logic          noc_clk;
  logic          noc_rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_flit;
  logic          in_is_header;
  logic          in_is_tail;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_flit;
  logic          out_is_header;
  logic          out_is_tail;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] err_count;
  logic          err_flag;

  noc_local_flit_buffer #(
    .FLIT_WIDTH (FW),
    .DEPTH      (4),
    .CNT_WIDTH  (CW)
  ) dut (
    .noc_clk       (noc_clk),
    .noc_rst       (noc_rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flit       (in_flit),
    .in_is_header  (in_is_header),
    .in_is_tail    (in_is_tail),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_flit      (out_flit),
    .out_is_header (out_is_header),
    .out_is_tail   (out_is_tail),
    .pkt_count     (pkt_count),
    .err_count     (err_count),
    .err_flag      (err_flag)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard of {header, tail, flit} words expected on the output, in order
  logic [FW+1:0] sb_q[$];

  // Reference framing model
  bit m_body = 0;
  int m_pkt  = 0;
  int m_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_accept(input logic [FW-1:0] f, input logic h, input logic t);
    if (!m_body) begin
      if (h) begin
        sb_q.push_back({h, t, f});
        if (t) m_pkt++;
        else   m_body = 1;
      end else begin
        if (m_err < 15) m_err++;
      end
    end else begin
      sb_q.push_back({h, t, f});
      if (h && m_err < 15) m_err++;
      if (t) begin
        m_pkt++;
        m_body = 0;
      end
    end
  endtask

  // Present a flit and hold it until accepted; returns #1 after the accepting edge
  task automatic send_flit(input logic [FW-1:0] f, input logic h, input logic t);
    int waited;
    in_valid     = 1'b1;
    in_flit      = f;
    in_is_header = h;
    in_is_tail   = t;
    waited       = 0;
    @(negedge noc_clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge noc_clk);
    end
    if (!in_ready) begin
      check("send_timeout", {31'b0, in_ready}, 32'd1);
    end else begin
      model_accept(f, h, t);
    end
    @(posedge noc_clk);
    #1;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_flit      = '0;
    in_is_header = 1'b0;
    in_is_tail   = 1'b0;
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      waited++;
      @(posedge noc_clk);
    end
    #1;
    check("drain_left", sb_q.size(), 32'd0);
  endtask

  // Output monitor: every output transfer must match the scoreboard head
  always @(negedge noc_clk) begin
    logic [FW+1:0] exp_w;
    if (!noc_rst && out_valid && out_ready) begin
      check("sb_has_entry", {31'b0, sb_q.size() > 0}, 32'd1);
      if (sb_q.size() > 0) begin
        exp_w = sb_q.pop_front();
        check("out_word", {22'b0, out_is_header, out_is_tail, out_flit}, {22'b0, exp_w});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    noc_rst   = 1'b1;
    out_ready = 1'b0;
    idle();
    repeat (3) @(posedge noc_clk);
    #1;
    // Reset state
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_word", {22'b0, out_is_header, out_is_tail, out_flit}, 32'd0);
    check("rst_pkt", {28'b0, pkt_count}, 32'd0);
    check("rst_err", {28'b0, err_count}, 32'd0);
    check("rst_flag", {31'b0, err_flag}, 32'd0);
    noc_rst = 1'b0;
    @(posedge noc_clk);
    #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // Three-flit packet with out_ready high, 1-cycle latency each
    out_ready = 1'b1;
    send_flit(8'hA1, 1'b1, 1'b0);
    check("t1_hdr_vld", {31'b0, out_valid}, 32'd1);
    check("t1_hdr_word", {22'b0, out_is_header, out_is_tail, out_flit}, {22'b0, 2'b10, 8'hA1});
    send_flit(8'hFF, 1'b0, 1'b0);
    check("t1_dat_word", {22'b0, out_is_header, out_is_tail, out_flit}, {22'b0, 2'b00, 8'hFF});
    send_flit(8'hB2, 1'b0, 1'b1);
    check("t1_tail_word", {22'b0, out_is_header, out_is_tail, out_flit}, {22'b0, 2'b01, 8'hB2});
    idle();
    wait_drain();
    check("t1_pkt", {28'b0, pkt_count}, m_pkt & 15);
    check("t1_err", {28'b0, err_count}, m_err);

    // Fill to full with out_ready low, fifth flit stalls
    out_ready = 1'b0;
    send_flit(8'h10, 1'b1, 1'b0);
    send_flit(8'h11, 1'b0, 1'b0);
    send_flit(8'h12, 1'b0, 1'b0);
    check("t2_rdy_after3", {31'b0, in_ready}, 32'd1);
    send_flit(8'h13, 1'b0, 1'b0);
    check("t2_rdy_full", {31'b0, in_ready}, 32'd0);
    in_flit    = 8'h14;
    in_is_tail = 1'b1;
    in_is_header = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge noc_clk);
      check("t2_held", {31'b0, in_ready}, 32'd0);
    end
    check("t2_sb_depth", sb_q.size(), 32'd4);
    out_ready = 1'b1;
    send_flit(8'h14, 1'b0, 1'b1);
    idle();
    wait_drain();
    check("t2_pkt", {28'b0, pkt_count}, m_pkt & 15);

    // Orphan data flit is dropped and flagged; a good packet still passes
    send_flit(8'h55, 1'b0, 1'b0);
    idle();
    check("t3_err", {28'b0, err_count}, m_err);
    check("t3_flag", {31'b0, err_flag}, 32'd1);
    send_flit(8'h61, 1'b1, 1'b0);
    send_flit(8'h62, 1'b0, 1'b0);
    send_flit(8'h63, 1'b0, 1'b1);
    idle();
    wait_drain();
    check("t3_pkt", {28'b0, pkt_count}, m_pkt & 15);

    // Header inside a packet: error, both headers forwarded, packet closes on tail
    send_flit(8'h71, 1'b1, 1'b0);
    send_flit(8'h72, 1'b0, 1'b0);
    send_flit(8'h73, 1'b1, 1'b0);
    idle();
    check("t4_err", {28'b0, err_count}, m_err);
    check("t4_pkt_open", {28'b0, pkt_count}, m_pkt & 15);
    send_flit(8'h74, 1'b0, 1'b0);
    send_flit(8'h75, 1'b0, 1'b1);
    idle();
    wait_drain();
    check("t4_pkt", {28'b0, pkt_count}, m_pkt & 15);

    // Error counter saturates at all-ones
    for (int i = 0; i < 16; i++) begin
      send_flit(8'(8'h80 + i), 1'b0, (i % 2) == 1);
    end
    idle();
    check("sat_err", {28'b0, err_count}, m_err);
    check("sat_pkt", {28'b0, pkt_count}, m_pkt & 15);

    // Reset with two flits stored discards them
    out_ready = 1'b0;
    send_flit(8'h31, 1'b1, 1'b0);
    send_flit(8'h32, 1'b0, 1'b0);
    idle();
    check("t5_pre_vld", {31'b0, out_valid}, 32'd1);
    noc_rst = 1'b1;
    @(posedge noc_clk);
    #1;
    sb_q.delete();
    m_body = 0;
    m_pkt  = 0;
    m_err  = 0;
    check("t5_out_valid", {31'b0, out_valid}, 32'd0);
    check("t5_pkt", {28'b0, pkt_count}, 32'd0);
    check("t5_err", {28'b0, err_count}, 32'd0);
    check("t5_flag", {31'b0, err_flag}, 32'd0);
    check("t5_in_ready_rst", {31'b0, in_ready}, 32'd0);
    noc_rst = 1'b0;
    @(posedge noc_clk);
    #1;
    check("t5_in_ready_rel", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    send_flit(8'h41, 1'b1, 1'b1);
    idle();
    wait_drain();
    check("t5_post_pkt", {28'b0, pkt_count}, m_pkt & 15);

`ifdef NOC_LOCAL_BUF_STORE_FWD_EN
    // Store-and-forward: nothing leaves until the tail is stored
    send_flit(8'hC1, 1'b1, 1'b0);
    send_flit(8'hC2, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge noc_clk);
      check("sf_hold", {31'b0, out_valid}, 32'd0);
    end
    @(posedge noc_clk);
    #1;
    send_flit(8'hC3, 1'b0, 1'b1);
    check("sf_release", {31'b0, out_valid}, 32'd1);
    idle();
    wait_drain();
`endif

    repeat (3) @(posedge noc_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_local_flit_buffer.md
Name: noc_local_flit_buffer

Overview:
- Flit buffer between a node's sender port and the router local input port.
- Buffers header/data/tail flits in a FIFO using a valid/ready handshake on both sides.
- Checks packet framing: a packet is one header, zero or more body flits, then one tail.
- Drops orphan flits and reports protocol errors and packet counts to the test bench.

Parameters:
- FLIT_WIDTH, default `Noc_Data_Width: flit payload width.
- DEPTH, default 4: FIFO entries; power of two, at least 2.
- CNT_WIDTH, default 16: width of the packet and error counters.

Ports:
- noc_clk, input, 1: the single clock.
- noc_rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: upstream flit valid.
- in_ready, output, 1: buffer can accept a flit.
- in_flit, input, FLIT_WIDTH: upstream flit.
- in_is_header, input, 1: flit is a packet header.
- in_is_tail, input, 1: flit is a packet tail.
- out_valid, output, 1: flit available to the router.
- out_ready, input, 1: router accepts the flit.
- out_flit, output, FLIT_WIDTH: head-of-FIFO flit.
- out_is_header, output, 1: head flit header flag.
- out_is_tail, output, 1: head flit tail flag.
- pkt_count, output, CNT_WIDTH: packets fully accepted (tail written).
- err_count, output, CNT_WIDTH: framing errors detected.
- err_flag, output, 1: sticky; set on the first error, cleared only by reset.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - in_ready=0 during reset, then 1 on the first cycle after reset is released.
  - out_valid=0, out_flit=0, out_is_header=0, out_is_tail=0.
  - pkt_count=0, err_count=0, err_flag=0.
  - FIFO pointers and occupancy cleared; framing FSM in IDLE.
- Reset mid-packet discards all stored flits; no partial flit is emitted afterwards.
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = !full, registered from next-state occupancy, so no combinational path from out_ready.
  - Simultaneous push and pop when full is not allowed: in_ready is already 0.
  - Simultaneous push and pop when empty: the flit is written and out_valid rises next cycle. No bypass; minimum latency is 1 cycle.
  - Outputs are driven from FIFO head registers and stay stable while out_valid && !out_ready.
- Occupancy counter is log2(DEPTH)+1 bits; read/write pointers are log2(DEPTH) bits and wrap naturally.
- Framing FSM advances on each accepted input flit:
  - IDLE, is_header=1, is_tail=0: write flit, go to BODY.
  - IDLE, header=1 and tail=1: write flit (single-flit packet), pkt_count+1, stay IDLE.
  - IDLE, header=0: flit dropped (not written), error.
  - BODY, header=0, tail=0: write flit, stay BODY.
  - BODY, tail=1, header=0: write flit, pkt_count+1, go to IDLE.
  - BODY, header=1: framing error. Write the new header (the old packet is abandoned), stay BODY, or go to IDLE if tail=1 as well.
- Any error: err_count+1 saturating at all-ones; err_flag<=1.
- A dropped flit is still handshaked (in_ready unaffected), so the sender never stalls on bad framing.
- pkt_count wraps modulo 2^CNT_WIDTH.

Optional Feature:
- Macro: NOC_LOCAL_BUF_STORE_FWD_EN.
- Defined (store-and-forward):
  - A tails_stored counter increments when a tail is written and decrements when a tail is popped; a push and pop of tails in the same cycle leaves it unchanged.
  - out_valid is asserted only if tails_stored>0, or the packet at the head is already being forwarded.
  - Once a header is popped, the rest of that packet flows whenever out_valid's FIFO is non-empty.
  - If the FIFO is full with tails_stored==0, forwarding is released in cut-through fashion to avoid deadlock, and err_flag is set (err_count unchanged).
- Undefined: cut-through; out_valid = !empty.

Test Plan:
- Reset, then push header(flit=0xA1), data(0xFF), tail(0xB2) with out_ready=1 → out emits 0xA1/h=1, 0xFF, 0xB2/t=1, each 1 cycle after its write; pkt_count=1, err_count=0.
- DEPTH=4, out_ready=0, push 5 flits back-to-back → in_ready drops after the 4th; the 5th is held; raise out_ready → all 5 emerge in order, with no loss or duplication.
- Data flit with no preceding header → not output, err_count=1, err_flag=1; a following valid 3-flit packet passes and pkt_count=1.
- Header, data, then a second header → err_count=1; both headers appear on out; the FSM stays BODY until a tail, then pkt_count=1.
- Assert noc_rst with 2 flits stored and out_ready=0 → next cycle out_valid=0, counters 0; in_ready=1 the cycle after release.
- With NOC_LOCAL_BUF_STORE_FWD_EN: push header and data, wait 10 cycles → out_valid stays 0; push tail → out_valid=1 the next cycle and all 3 flits stream out.
